// File: rtl/drum_ctrl_pkg.sv
// Shared types for the drum relay controller: state and direction encodings, latched target, width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package my_types;

    // The state encoding is visible to the MCU through state_o, so the values are fixed here.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DEAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    // Command direction codes.  The spare code 11 means stop as well.
    typedef enum logic [1:0] {
        DIR_STOP     = 2'b00,
        DIR_FWD      = 2'b01,
        DIR_REV      = 2'b10,
        DIR_STOP_ALT = 2'b11
    } dir_e;

    localparam int VEL_W = 3;

    // Direction and velocity that the controller is working towards.
    typedef struct packed {
        dir_e             dir;
        logic [VEL_W-1:0] vel;
    } target_t;

    // Number of bits needed to represent value (at least one).
    function automatic int GET_WIDTH(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Folds the spare direction code onto stop so the FSM only sees three directions.
    function automatic dir_e norm_dir(input logic [1:0] raw);
        dir_e d;
        if (raw == DIR_STOP_ALT) begin
            d = DIR_STOP;
        end else begin
            d = dir_e'(raw);
        end
        return d;
    endfunction

endpackage

// File: rtl/drum_ctrl_sync2.sv
// Two-flop synchronizer for one asynchronous pin, with the reset value chosen per instance.
// Latency: 2 clk from pin change to q.
// Backpressure: none; free-running.
module drum_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values of the chain: first stage samples the pin, second stage follows the first.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Chain registers.  Reset puts both stages at the pin's safe level so no fault is seen spuriously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/drum_ctrl.sv
// Drum relay sequencer: break-before-make direction relays, velocity settle, fault lockout.
// Latency: relay outputs change 1 clk after the deciding cycle; pin faults reach the relays in 3 clk.
// Backpressure: cmd_ready is low outside IDLE/RUN or while a fault condition is present.
module drum_ctrl #(
    parameter int DEAD_CYCLES   = 7_200_000,
    parameter int SETTLE_CYCLES = 3_600_000
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    input  logic [2:0] cmd_vel,
    output logic       cmd_ready,
    input  logic       wire_break,
    input  logic       power_OK,
    input  logic       wb_ena,
    input  logic       fault_clr,
    output logic       drum_fwd,
    output logic       drum_rev,
    output logic [2:0] drum_vel,
    output logic       busy,
    output logic       fault,
    output logic [1:0] fault_cause,
    output logic [2:0] state_o
);

    import my_types::*;

    // DEAD_CYCLES and SETTLE_CYCLES must both be at least 2; the timer reload is N-1 and
    // a reload of zero would collapse the phase into a single cycle.
    localparam int TW_MAX = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int TW     = GET_WIDTH(TW_MAX);

    localparam logic [TW-1:0] DEAD_LOAD   = TW'(DEAD_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    state_e           state_q;
    state_e           state_d;
    logic [TW-1:0]    timer_q;
    logic [TW-1:0]    timer_d;
    target_t          target_q;
    target_t          target_d;
    logic             drum_fwd_q;
    logic             drum_fwd_d;
    logic             drum_rev_q;
    logic             drum_rev_d;
    logic [VEL_W-1:0] drum_vel_q;
    logic [VEL_W-1:0] drum_vel_d;
    logic [1:0]       fault_cause_q;
    logic [1:0]       fault_cause_d;

    logic       wire_break_s;
    logic       power_ok_s;
    logic [1:0] fault_vec;
    logic       fault_cond;
    logic       cmd_accept;
    logic       timer_zero;
    dir_e       cmd_dir_n;

    // Pin synchronizers: a broken wire idles low, a healthy supply idles high.
    drum_sync2 #(.RST_VAL(1'b0)) u_sync_wire_break (
        .clk (clk),
        .rst (aclr),
        .d   (wire_break),
        .q   (wire_break_s)
    );

    drum_sync2 #(.RST_VAL(1'b1)) u_sync_power_ok (
        .clk (clk),
        .rst (aclr),
        .d   (power_OK),
        .q   (power_ok_s)
    );

    // Fault sources in fault_cause bit order, plus handshake and timer status.
    always_comb begin
        fault_vec  = {~power_ok_s, wire_break_s & wb_ena};
        fault_cond = |fault_vec;
        cmd_dir_n  = norm_dir(cmd_dir);
        cmd_ready  = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !fault_cond;
        cmd_accept = cmd_valid && cmd_ready;
        timer_zero = (timer_q == '0);
    end

    // State register together with the registered relay outputs and sticky fault cause.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            target_q      <= '{dir: DIR_STOP, vel: '0};
            drum_fwd_q    <= 1'b0;
            drum_rev_q    <= 1'b0;
            drum_vel_q    <= '0;
            fault_cause_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            target_q      <= target_d;
            drum_fwd_q    <= drum_fwd_d;
            drum_rev_q    <= drum_rev_d;
            drum_vel_q    <= drum_vel_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    // Next-state logic: command decode, phase timer, fault entry and acknowledge.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        timer_d  = timer_zero ? '0 : (timer_q - TIMER_ONE);

        if (fault_cond && (state_q != ST_FAULT)) begin
            // Fault wins over any command presented in the same cycle.
            state_d      = ST_FAULT;
            target_d.dir = DIR_STOP;
            target_d.vel = '0;
            timer_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        target_d.dir = cmd_dir_n;
                        target_d.vel = cmd_vel;
                        if (cmd_dir_n != DIR_STOP) begin
                            state_d = ST_SETTLE;
                            timer_d = SETTLE_LOAD;
                        end
                    end
                end
                ST_RUN: begin
                    if (cmd_accept) begin
                        target_d.dir = cmd_dir_n;
                        target_d.vel = cmd_vel;
                        if (cmd_dir_n == target_q.dir) begin
                            // Same direction: only a velocity change needs a settle phase.
                            if (cmd_vel != target_q.vel) begin
                                state_d = ST_SETTLE;
                                timer_d = SETTLE_LOAD;
                            end
                        end else begin
                            // Reversal or stop: open the direction relay and wait out the dead time.
                            state_d = ST_DEAD;
                            timer_d = DEAD_LOAD;
                        end
                    end
                end
                ST_DEAD: begin
                    if (timer_zero) begin
                        if (target_q.dir == DIR_STOP) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_SETTLE;
                            timer_d = SETTLE_LOAD;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && !fault_cond) begin
                        state_d      = ST_DEAD;
                        timer_d      = DEAD_LOAD;
                        target_d.dir = DIR_STOP;
                        target_d.vel = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Output logic: relay next values keyed on the transition taken, so a direction relay
    // only ever closes on SETTLE->RUN, after the velocity relays have already moved.
    always_comb begin
        drum_fwd_d    = drum_fwd_q;
        drum_rev_d    = drum_rev_q;
        drum_vel_d    = drum_vel_q;
        fault_cause_d = fault_cause_q | fault_vec;

        if ((state_q != ST_FAULT) && (state_d == ST_FAULT)) begin
            drum_fwd_d = 1'b0;
            drum_rev_d = 1'b0;
            drum_vel_d = '0;
        end else if ((state_q == ST_FAULT) && (state_d == ST_DEAD)) begin
            fault_cause_d = '0;
        end else begin
            if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
                drum_vel_d = target_d.vel;
            end
            if ((state_q == ST_RUN) && (state_d == ST_DEAD)) begin
                drum_fwd_d = 1'b0;
                drum_rev_d = 1'b0;
            end
            if ((state_q == ST_DEAD) && (state_d == ST_IDLE)) begin
                drum_vel_d = '0;
            end
            if ((state_q == ST_SETTLE) && (state_d == ST_RUN)) begin
                drum_fwd_d = (target_q.dir == DIR_FWD);
                drum_rev_d = (target_q.dir == DIR_REV);
            end
        end

        drum_fwd    = drum_fwd_q;
        drum_rev    = drum_rev_q;
        drum_vel    = drum_vel_q;
        fault_cause = fault_cause_q;
        busy        = (state_q != ST_IDLE) && (state_q != ST_RUN);
        fault       = (state_q == ST_FAULT);
        state_o     = state_q;
    end

endmodule

// File: tb/tb_drum_ctrl.sv
// Directed bench for drum_ctrl with short dead/settle times.
// Latency: steps are one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: commands are presented for one cycle and cmd_ready is checked where it matters.
module tb_drum_ctrl;

    localparam logic [31:0] S_IDLE   = 32'd0;
    localparam logic [31:0] S_RUN    = 32'd1;
    localparam logic [31:0] S_DEAD   = 32'd2;
    localparam logic [31:0] S_SETTLE = 32'd3;
    localparam logic [31:0] S_FAULT  = 32'd4;

    logic       clk;
    logic       aclr;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic [2:0] cmd_vel;
    logic       cmd_ready;
    logic       wire_break;
    logic       power_OK;
    logic       wb_ena;
    logic       fault_clr;
    logic       drum_fwd;
    logic       drum_rev;
    logic [2:0] drum_vel;
    logic       busy;
    logic       fault;
    logic [1:0] fault_cause;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;
    logic       prev_fwd = 1'b0;
    logic       prev_rev = 1'b0;
    logic [2:0] prev_vel = 3'd0;

    drum_ctrl #(
        .DEAD_CYCLES   (10),
        .SETTLE_CYCLES (5)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .cmd_valid   (cmd_valid),
        .cmd_dir     (cmd_dir),
        .cmd_vel     (cmd_vel),
        .cmd_ready   (cmd_ready),
        .wire_break  (wire_break),
        .power_OK    (power_OK),
        .wb_ena      (wb_ena),
        .fault_clr   (fault_clr),
        .drum_fwd    (drum_fwd),
        .drum_rev    (drum_rev),
        .drum_vel    (drum_vel),
        .busy        (busy),
        .fault       (fault),
        .fault_cause (fault_cause),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one command for one cycle; afterwards the values of cycle T+1 are visible.
    task automatic send(input logic [1:0] d, input logic [2:0] v);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_vel   = v;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
    endtask

    // Relay rules every cycle: never both directions, never a relay closing while velocity moves.
    always @(negedge clk) begin
        if (mon_en && !aclr) begin
            total++;
            assert (!(drum_fwd && drum_rev) &&
                    !((((drum_fwd && !prev_fwd) || (drum_rev && !prev_rev))) && (drum_vel != prev_vel))) else begin
                bad++;
                $error("FAIL relay_rules fwd=%0b rev=%0b vel=%0d prev_vel=%0d", drum_fwd, drum_rev, drum_vel, prev_vel);
            end
        end
        prev_fwd = drum_fwd;
        prev_rev = drum_rev;
        prev_vel = drum_vel;
    end

    initial begin
        aclr = 1'b1; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_vel = 3'd0;
        wire_break = 1'b0; power_OK = 1'b1; wb_ena = 1'b1; fault_clr = 1'b0;
        step(3);
        chk("rst_state", state_o, S_IDLE);
        chk("rst_fwd", drum_fwd, 0);
        chk("rst_rev", drum_rev, 0);
        chk("rst_vel", drum_vel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cause", fault_cause, 0);
        aclr = 1'b0;
        step(1);
        mon_en = 1;
        chk("idle_ready", cmd_ready, 1);

        // Stop in IDLE does nothing.
        send(2'b00, 3'd2);
        chk("idle_stop_state", state_o, S_IDLE);
        chk("idle_stop_vel", drum_vel, 0);

        // IDLE -> fwd vel 3.
        cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_vel = 3'd3; #1;
        chk("fwd_ready", cmd_ready, 1);
        step(1);
        cmd_valid = 1'b0;
        chk("fwd_t1_vel", drum_vel, 3);
        chk("fwd_t1_state", state_o, S_SETTLE);
        chk("fwd_t1_fwd", drum_fwd, 0);
        chk("fwd_t1_ready", cmd_ready, 0);
        chk("fwd_t1_busy", busy, 1);
        step(4);
        chk("fwd_t5_fwd", drum_fwd, 0);
        chk("fwd_t5_state", state_o, S_SETTLE);
        step(1);
        chk("fwd_t6_fwd", drum_fwd, 1);
        chk("fwd_t6_rev", drum_rev, 0);
        chk("fwd_t6_state", state_o, S_RUN);
        chk("fwd_t6_busy", busy, 0);

        // RUN fwd 3 -> fwd 6: velocity change with relay held.
        send(2'b01, 3'd6);
        chk("vel_t1_vel", drum_vel, 6);
        chk("vel_t1_fwd", drum_fwd, 1);
        chk("vel_t1_state", state_o, S_SETTLE);
        chk("vel_t1_ready", cmd_ready, 0);
        for (int i = 2; i <= 5; i++) begin
            step(1);
            chk("vel_mid_ready", cmd_ready, 0);
            chk("vel_mid_fwd", drum_fwd, 1);
        end
        step(1);
        chk("vel_t6_state", state_o, S_RUN);
        chk("vel_t6_ready", cmd_ready, 1);

        // Same direction, same velocity: no-op.
        send(2'b01, 3'd6);
        chk("noop_state", state_o, S_RUN);
        chk("noop_fwd", drum_fwd, 1);

        // RUN fwd -> rev 5: break, dead time, settle, make.
        send(2'b10, 3'd5);
        chk("rev_t1_fwd", drum_fwd, 0);
        chk("rev_t1_rev", drum_rev, 0);
        chk("rev_t1_state", state_o, S_DEAD);
        step(9);
        chk("rev_t10_state", state_o, S_DEAD);
        chk("rev_t10_vel", drum_vel, 6);
        step(1);
        chk("rev_t11_vel", drum_vel, 5);
        chk("rev_t11_state", state_o, S_SETTLE);
        step(4);
        chk("rev_t15_rev", drum_rev, 0);
        step(1);
        chk("rev_t16_rev", drum_rev, 1);
        chk("rev_t16_state", state_o, S_RUN);

        // Wire break while running.
        wire_break = 1'b1;
        step(2);
        chk("wb_e2_rev", drum_rev, 1);
        chk("wb_e2_ready", cmd_ready, 0);
        step(1);
        chk("wb_e3_rev", drum_rev, 0);
        chk("wb_e3_vel", drum_vel, 0);
        chk("wb_e3_fault", fault, 1);
        chk("wb_e3_cause", fault_cause, 2'b01);
        chk("wb_e3_state", state_o, S_FAULT);
        pulse_clr();
        chk("wb_clr_ignored", state_o, S_FAULT);
        wire_break = 1'b0;
        step(3);
        chk("wb_hold_state", state_o, S_FAULT);
        chk("wb_hold_cause", fault_cause, 2'b01);
        pulse_clr();
        chk("wb_clr_state", state_o, S_DEAD);
        chk("wb_clr_cause", fault_cause, 0);
        chk("wb_clr_fault", fault, 0);
        step(9);
        chk("wb_dead_end", state_o, S_DEAD);
        step(1);
        chk("wb_idle_state", state_o, S_IDLE);
        chk("wb_idle_ready", cmd_ready, 1);

        // Command in the same cycle the synchronized power loss arrives.
        power_OK = 1'b0;
        step(2);
        cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_vel = 3'd2; #1;
        chk("pl_ready", cmd_ready, 0);
        step(1);
        cmd_valid = 1'b0;
        chk("pl_state", state_o, S_FAULT);
        chk("pl_cause", fault_cause, 2'b10);
        chk("pl_vel", drum_vel, 0);

        // Fault during the post-acknowledge dead time re-enters FAULT.
        power_OK = 1'b1;
        step(3);
        pulse_clr();
        chk("pl_clr_state", state_o, S_DEAD);
        step(2);
        wire_break = 1'b1;
        step(3);
        chk("dead_refault_state", state_o, S_FAULT);
        chk("dead_refault_cause", fault_cause, 2'b01);
        wire_break = 1'b0;
        step(3);
        pulse_clr();
        step(10);
        chk("refault_idle", state_o, S_IDLE);

        // Reset in the middle of SETTLE.
        send(2'b01, 3'd4);
        chk("mid_settle_vel", drum_vel, 4);
        step(2);
        aclr = 1'b1;
        #1;
        chk("arst_vel", drum_vel, 0);
        chk("arst_fwd", drum_fwd, 0);
        chk("arst_state", state_o, S_IDLE);
        step(1);
        aclr = 1'b0;
        step(1);
        chk("arst_rel_state", state_o, S_IDLE);
        chk("arst_rel_ready", cmd_ready, 1);

        // Reset released with power already lost.
        power_OK = 1'b0;
        aclr = 1'b1;
        step(1);
        aclr = 1'b0;
        step(2);
        chk("rst_pl_e2_state", state_o, S_IDLE);
        step(1);
        chk("rst_pl_e3_state", state_o, S_FAULT);
        chk("rst_pl_e3_cause", fault_cause, 2'b10);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
